crank_decoder: RTL and testbench

CRANK_DECODER -- requirements
Module: crank_decoder

---
 rtl/crank_pkg.sv | 14 +
 rtl/sync_edge.sv | 43 ++++
 rtl/crank_decoder.sv | 166 ++++++++++++++++
 tb/tb_crank_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crank_pkg.sv
// Shared defaults and FSM state encoding for the crank-angle decoder.
package crank_pkg;

  localparam int TEETH_PER_REV_DEF = 134;
  localparam int PERIOD_W_DEF      = 24;
  localparam int STALL_CYCLES_DEF  = 2**20;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_SYNCED = 2'd2
  } crank_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall strobes for one async input.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_stb,
  output logic fall_stb
);

  // [0] metastable stage, [1] stable sample, [2] previous stable sample
  logic [2:0] sync_q, sync_d;
  // Walks in ones after reset; strobes stay masked until [2] holds a real sample,
  // so a high input at reset release is not mistaken for an edge.
  logic [2:0] arm_q, arm_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
    arm_d  = {arm_q[1:0], 1'b1};
    rise_d = arm_q[2] &  sync_q[1] & ~sync_q[2];
    fall_d = arm_q[2] & ~sync_q[1] &  sync_q[2];
  end

  // NOTE: every flop uses a non-blocking assignment so all stages shift together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      arm_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      arm_q  <= arm_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_stb = rise_q;
  assign fall_stb = fall_q;

endmodule

// File: rtl/crank_decoder.sv
// Crank-wheel decoder: tooth period measurement, angular position tracking and stall detection.
module crank_decoder
  import crank_pkg::*;
#(
  parameter int TEETH_PER_REV = TEETH_PER_REV_DEF,
  parameter int PERIOD_W      = PERIOD_W_DEF,
  parameter int STALL_CYCLES  = STALL_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                speed_in,
  input  logic                ref_in,
  input  logic                err_clr,
  output logic                tooth_stb,
  output logic                ref_stb,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                period_valid,
  output logic [7:0]          tooth_idx,
  output logic                synced,
  output logic                stall,
  output logic                rev_err,
  output logic                err
);

  localparam logic [7:0]          LAST_IDX  = 8'(TEETH_PER_REV - 1);
  localparam logic [PERIOD_W-1:0] STALL_LIM = PERIOD_W'(STALL_CYCLES - 1);

  logic tooth_ev, ref_ev;
  logic speed_fall_unused, ref_rise_unused;

  sync_edge u_speed_edge (
    .clk      (clk),
    .rst      (rst),
    .din      (speed_in),
    .rise_stb (tooth_ev),
    .fall_stb (speed_fall_unused)
  );

  sync_edge u_ref_edge (
    .clk      (clk),
    .rst      (rst),
    .din      (ref_in),
    .rise_stb (ref_rise_unused),
    .fall_stb (ref_ev)
  );

  crank_state_e        state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [7:0]          idx_q, idx_d;
  logic                seen_q, seen_d;
  logic                valid_q, valid_d;
  logic                ref_pend_q, ref_pend_d;
  logic                tooth_stb_q, tooth_stb_d;
  logic                ref_stb_q, ref_stb_d;
  logic                synced_q, synced_d;
  logic                stall_q, stall_d;
  logic                rev_err_q, rev_err_d;
  logic                err_q, err_d;
  logic                ref_tooth;

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path infers a latch.
    state_d     = state_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    cnt_d       = cnt_inc;
    period_d    = period_q;
    idx_d       = idx_q;
    seen_d      = seen_q;
    valid_d     = valid_q;
    ref_pend_d  = ref_pend_q | ref_ev;
    tooth_stb_d = tooth_ev;
    ref_stb_d   = ref_ev;
    stall_d     = stall_q;
    rev_err_d   = 1'b0;
    ref_tooth   = tooth_ev & (ref_pend_q | ref_ev);

    if (tooth_ev) begin
      period_d   = cnt_inc;
      cnt_d      = '0;
      stall_d    = 1'b0;
      valid_d    = seen_q;
      seen_d     = 1'b1;
      ref_pend_d = 1'b0;
      case (state_q)
        ST_HUNT: begin
          if (ref_tooth) begin
            idx_d   = '0;
            state_d = ST_VERIFY;
          end
        end
        default: begin
          if (ref_tooth) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_SYNCED;
            end else begin
              rev_err_d = 1'b1;
              state_d   = ST_VERIFY;
            end
          end else if (idx_q == LAST_IDX) begin
            // A full revolution of teeth without a reference mark.
            rev_err_d = 1'b1;
            idx_d     = '0;
            state_d   = ST_HUNT;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      endcase
    end else if (cnt_q == STALL_LIM) begin
      stall_d    = 1'b1;
      valid_d    = 1'b0;
      seen_d     = 1'b0;
      ref_pend_d = 1'b0;
      state_d    = ST_HUNT;
    end

    synced_d = (state_d == ST_SYNCED);
    // A new error wins over a simultaneous clear.
    err_d    = rev_err_d | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      period_q    <= '0;
      idx_q       <= '0;
      seen_q      <= 1'b0;
      valid_q     <= 1'b0;
      ref_pend_q  <= 1'b0;
      tooth_stb_q <= 1'b0;
      ref_stb_q   <= 1'b0;
      synced_q    <= 1'b0;
      stall_q     <= 1'b0;
      rev_err_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      idx_q       <= idx_d;
      seen_q      <= seen_d;
      valid_q     <= valid_d;
      ref_pend_q  <= ref_pend_d;
      tooth_stb_q <= tooth_stb_d;
      ref_stb_q   <= ref_stb_d;
      synced_q    <= synced_d;
      stall_q     <= stall_d;
      rev_err_q   <= rev_err_d;
      err_q       <= err_d;
    end
  end

  assign tooth_stb    = tooth_stb_q;
  assign ref_stb      = ref_stb_q;
  assign tooth_period = period_q;
  assign period_valid = valid_q;
  assign tooth_idx    = idx_q;
  assign synced       = synced_q;
  assign stall        = stall_q;
  assign rev_err      = rev_err_q;
  assign err          = err_q;

endmodule

// File: tb/tb_crank_decoder.sv
// Directed bench for crank_decoder: sync, ramp, ref errors, missing ref, reset and stall.
module tb_crank_decoder;

  localparam int TEETH = 134;
  localparam int PW    = 24;
  localparam int STALL = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          speed_in;
  logic          ref_in;
  logic          err_clr;
  logic          tooth_stb;
  logic          ref_stb;
  logic [PW-1:0] tooth_period;
  logic          period_valid;
  logic [7:0]    tooth_idx;
  logic          synced;
  logic          stall;
  logic          rev_err;
  logic          err;

  crank_decoder #(
    .TEETH_PER_REV (TEETH),
    .PERIOD_W      (PW),
    .STALL_CYCLES  (STALL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .speed_in     (speed_in),
    .ref_in       (ref_in),
    .err_clr      (err_clr),
    .tooth_stb    (tooth_stb),
    .ref_stb      (ref_stb),
    .tooth_period (tooth_period),
    .period_valid (period_valid),
    .tooth_idx    (tooth_idx),
    .synced       (synced),
    .stall        (stall),
    .rev_err      (rev_err),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs captured on the cycle a tooth strobe is expected.
  logic          s_stb, s_synced, s_valid, s_rev, s_rev_late, s_err, s_err_late, s_stall;
  logic [7:0]    s_idx;
  logic [PW-1:0] s_period;
  int            t_stb;
  int            ref_hold = 0;

  // One tooth of period p starting with the rising edge; ref_now drops ref_in on
  // the same edge, ref_next drops it in the low phase ahead of the next tooth.
  task automatic tooth(input int p, input bit ref_next, input bit ref_now);
    speed_in = 1'b1;
    if (ref_now) begin
      ref_in   = 1'b0;
      ref_hold = 2;
    end
    repeat (3) @(negedge clk);
    check("tooth_stb_early", tooth_stb, 0);
    @(negedge clk);
    check("tooth_stb", tooth_stb, 1);
    s_synced = synced;
    s_valid  = period_valid;
    s_idx    = tooth_idx;
    s_period = tooth_period;
    s_rev    = rev_err;
    s_err    = err;
    s_stall  = stall;
    t_stb    = cyc;
    @(negedge clk);
    check("tooth_stb_width", tooth_stb, 0);
    s_rev_late = rev_err;
    s_err_late = err;
    repeat (p/2 - 5) @(negedge clk);
    speed_in = 1'b0;
    if (ref_hold > 0) begin
      ref_hold--;
      if (ref_hold == 0) ref_in = 1'b1;
    end
    if (ref_next) begin
      ref_in   = 1'b0;
      ref_hold = 2;
      repeat (3) @(negedge clk);
      check("ref_stb_early", ref_stb, 0);
      @(negedge clk);
      check("ref_stb", ref_stb, 1);
      @(negedge clk);
      check("ref_stb_width", ref_stb, 0);
      repeat (p - p/2 - 5) @(negedge clk);
    end else begin
      repeat (p - p/2) @(negedge clk);
    end
  endtask

  // From HUNT: same-cycle ref tooth, one revolution in VERIFY, then a ref tooth into SYNCED.
  task automatic sync_up(input int p);
    tooth(p, 1'b0, 1'b1);
    check("sync_up_first_idx", s_idx, 0);
    check("sync_up_first_synced", s_synced, 0);
    for (int k = 1; k < TEETH; k++) begin
      tooth(p, k == TEETH - 1, 1'b0);
      check("sync_up_idx", s_idx, k);
    end
    tooth(p, 1'b0, 1'b0);
    check("sync_up_synced", s_synced, 1);
    check("sync_up_idx0", s_idx, 0);
    check("sync_up_no_rev_err", s_rev, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tooth_stb"}, tooth_stb, 0);
    check({tag, "_ref_stb"}, ref_stb, 0);
    check({tag, "_period"}, tooth_period, 0);
    check({tag, "_valid"}, period_valid, 0);
    check({tag, "_idx"}, tooth_idx, 0);
    check({tag, "_synced"}, synced, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_rev_err"}, rev_err, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit spurious;
    int prev_p;
    int q;
    int n;

    // Reset with speed_in and ref_in both high through release.
    rst      = 1'b1;
    speed_in = 1'b1;
    ref_in   = 1'b1;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    spurious = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tooth_stb || ref_stb) spurious = 1'b1;
    end
    check("no_strobe_after_release", spurious, 0);
    speed_in = 1'b0;
    repeat (5) @(negedge clk);

    // Period 100, ref pending ahead of the first tooth.
    ref_in   = 1'b0;
    ref_hold = 2;
    repeat (3) @(negedge clk);
    check("first_ref_stb_early", ref_stb, 0);
    @(negedge clk);
    check("first_ref_stb", ref_stb, 1);
    @(negedge clk);
    check("first_ref_stb_width", ref_stb, 0);
    repeat (10) @(negedge clk);
    tooth(100, 1'b0, 1'b0);
    check("hunt_ref_idx", s_idx, 0);
    check("hunt_ref_synced", s_synced, 0);
    check("first_tooth_valid", s_valid, 0);
    for (int k = 1; k < TEETH; k++) begin
      tooth(100, k == TEETH - 1, 1'b0);
      check("verify_idx", s_idx, k);
      if (k == 1) begin
        check("second_tooth_valid", s_valid, 1);
        check("second_tooth_period", s_period, 100);
      end
    end
    check("verify_not_synced", s_synced, 0);
    tooth(100, 1'b0, 1'b0);
    check("second_ref_synced", s_synced, 1);
    check("second_ref_idx", s_idx, 0);
    check("second_ref_no_err", s_rev, 0);
    check("steady_period", s_period, 100);

    // Period ramp 200 -> 100 in steps of 4; each is measured on the following tooth.
    prev_p = 100;
    q      = 1;
    for (int p = 200; p >= 100; p -= 4) begin
      tooth(p, 1'b0, 1'b0);
      check("ramp_period", s_period, prev_p);
      check("ramp_idx", s_idx, q);
      prev_p = p;
      q++;
    end
    tooth(20, 1'b0, 1'b0);
    check("ramp_last_period", s_period, 100);
    check("ramp_last_idx", s_idx, q);
    q++;

    // Early reference while SYNCED.
    for (int k = q; k <= 129; k++) begin
      tooth(20, k == 129, 1'b0);
      check("early_ref_idx", s_idx, k);
    end
    check("early_ref_was_synced", s_synced, 1);
    tooth(20, 1'b0, 1'b0);
    check("early_ref_rev_err", s_rev, 1);
    check("early_ref_rev_err_width", s_rev_late, 0);
    check("early_ref_err", s_err, 1);
    check("early_ref_synced", s_synced, 0);
    check("early_ref_idx0", s_idx, 0);
    tooth(20, 1'b0, 1'b0);
    check("early_ref_verify_idx", s_idx, 1);
    check("early_ref_verify_synced", s_synced, 0);
    check("err_sticky", s_err, 1);

    // Reference withheld: the tooth after idx 133 is a missing-ref error.
    for (int k = 2; k < TEETH; k++) begin
      tooth(20, 1'b0, 1'b0);
      check("missing_ref_idx", s_idx, k);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", err, 0);
    err_clr = 1'b1;
    tooth(20, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("missing_ref_rev_err", s_rev, 1);
    check("err_set_beats_clr", s_err, 1);
    check("err_clr_after", s_err_late, 0);
    check("missing_ref_idx0", s_idx, 0);
    check("missing_ref_synced", s_synced, 0);
    tooth(20, 1'b0, 1'b0);
    check("hunt_plain_idx", s_idx, 0);

    // Reset mid-revolution while SYNCED, then resynchronise.
    sync_up(20);
    for (int k = 1; k <= 5; k++) begin
      tooth(20, 1'b0, 1'b0);
      check("pre_rst_idx", s_idx, k);
    end
    check("pre_rst_synced", synced, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sync_up(20);

    // Teeth stop: stall exactly STALL cycles after the last tooth strobe.
    tooth(20, 1'b0, 1'b0);
    check("pre_stall_idx", s_idx, 1);
    n = 0;
    while (stall !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("stall_seen", stall, 1);
    check("stall_delay", cyc - t_stb, STALL);
    check("stall_synced", synced, 0);
    check("stall_valid", period_valid, 0);
    tooth(20, 1'b0, 1'b0);
    check("stall_cleared", s_stall, 0);
    check("post_stall_valid", s_valid, 0);
    tooth(20, 1'b0, 1'b0);
    check("post_stall_valid2", s_valid, 1);
    check("post_stall_period", s_period, 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
